uart_word_collector: RTL
========================

Name: uart_word_collector

Overview:
- Receive-side counterpart of the 32-bit word transmitter FSM.
- Once armed, collects NBYTES consecutive bytes from the UART receiver, least-significant byte first, and assembles them into one word.
- Publishes the word with a one-cycle done pulse. Aborts with an error pulse if the gap between bytes exceeds a timeout.
- Sits between the UART rx core and the command/matrix-load logic.

Parameters:
- NBYTES, 4, bytes per word; word width is 8*NBYTES.
- TIMEOUT_CYCLES, 100000, maximum clk cycles allowed between consecutive bytes once the first byte has arrived.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- en_rxMAN  in  1  arm request; sampled only in IDLE.
- rx_ready  in  1  one-cycle strobe from the UART rx; rx_data is valid in that cycle.
- rx_data  in  8  received byte.
- man  out  8*NBYTES  last successfully assembled word.
- done_rxMAN  out  1  one-cycle pulse: man has just been updated.
- timeout_err  out  1  one-cycle pulse: partial word discarded.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - man=0, done_rxMAN=0, timeout_err=0, busy=0.
  - Internal shadow register=0, byte index=0, timer=0, state=IDLE.
- Reset has priority over all other inputs. Reset mid-word discards the partial word and clears man to 0.
- States: IDLE, WAIT_BYTE, FINISH, ERROR. All outputs are registered (Moore).
- IDLE:
  - en_rxMAN=1 -> WAIT_BYTE; index and timer are cleared on the same edge.
  - rx_ready in IDLE is ignored (no capture).
- WAIT_BYTE, rx_ready=1:
  - rx_data is written to shadow[8*index+7 : 8*index].
  - index increments and the timer clears.
  - If index was NBYTES-1 -> FINISH; else stay in WAIT_BYTE.
- WAIT_BYTE timer:
  - Runs only when index>0 (before the first byte the block waits indefinitely).
  - Increments every cycle without rx_ready.
  - Reaching TIMEOUT_CYCLES-1 with no rx_ready -> ERROR.
- Simultaneous events:
  - rx_ready in the same cycle the timer hits its limit: the byte wins and no error is raised.
  - en_rxMAN while busy=1 is ignored.
- FINISH (one cycle):
  - man <= shadow, done_rxMAN=1 in this cycle, then -> IDLE.
  - rx_ready in FINISH is ignored (dropped, not queued).
- ERROR (one cycle):
  - timeout_err=1 and the shadow register is cleared; man is unchanged; then -> IDLE.
- Latency: done_rxMAN rises on the first edge after the edge that captured the last byte; man is valid in that same cycle and holds until the next FINISH or reset.
- Bytes that are not overwritten keep stale shadow contents only internally. man is only ever loaded from a complete NBYTES set.
- Widths:
  - Index width is clog2(NBYTES)+1.
  - Timer width is clog2(TIMEOUT_CYCLES)+1 and saturates, never wrapping.
- Back-to-back words: after a done pulse, returning to IDLE costs one cycle; the next en_rxMAN is accepted from IDLE.

Test Plan:
- Basic word:
  - Stimulus: reset; en_rxMAN pulse; bytes 0x78,0x56,0x34,0x12 spaced 10 cycles apart.
  - Required: man=0x12345678; done_rxMAN high for exactly 1 cycle, 2 edges after the last strobe; busy low afterwards.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=50; arm; send 0xAA then nothing.
  - Required: timeout_err pulses 50 cycles after the 0xAA strobe; man keeps its prior value; a following full word 0x01,0x02,0x03,0x04 gives man=0x04030201.
- Timeout boundary:
  - Stimulus: second byte arrives exactly in the cycle the timer reaches 49.
  - Required: byte accepted; no timeout_err.
- Ignored inputs:
  - Stimulus: rx_ready strobes while in IDLE; en_rxMAN re-pulsed mid-word.
  - Required: no capture, no restart; word assembles from post-arm bytes only.
- Reset mid-word:
  - Stimulus: after 2 of 4 bytes, assert reset for 1 cycle.
  - Required: man=0, busy=0, no done_rxMAN or timeout_err; the next armed word assembles correctly.
- Back-to-back:
  - Stimulus: two armed words 0xDEADBEEF then 0xCAFEF00D, re-armed the cycle after the first done.
  - Required: two done pulses with man values in order.

Source files
------------

// File: rtl/uart_word_collector.sv
// -----------------------------------------------------------------------------
// uart_word_collector
//
// Assembles NBYTES consecutive bytes from the UART receiver into one word,
// least-significant byte first. Once armed, the block waits indefinitely for
// the first byte. After that, each following byte must arrive within
// TIMEOUT_CYCLES clocks, or the partial word is discarded.
// A complete word is published on man together with a one-cycle done pulse.
// All outputs are registered (Moore).
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high
//   en_rxMAN     in   arm request, honoured only while idle
//   rx_ready     in   one-cycle byte strobe from the UART rx core
//   rx_data      in   received byte, valid while rx_ready is high
//   man          out  last completely assembled word
//   done_rxMAN   out  one-cycle pulse, man has just been updated
//   timeout_err  out  one-cycle pulse, partial word discarded
//   busy         out  high in every state except IDLE
// -----------------------------------------------------------------------------
module uart_word_collector #(
   parameter int NBYTES         = 4,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en_rxMAN,
   input  logic                  rx_ready,
   input  logic [7:0]            rx_data,
   output logic [8*NBYTES-1:0]   man,
   output logic                  done_rxMAN,
   output logic                  timeout_err,
   output logic                  busy
);

   localparam int IDX_W = $clog2(NBYTES) + 1;
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NBYTES - 1);
   localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMR_MAX   = '1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_BYTE,
      ST_FINISH,
      ST_ERROR
   } state_t;

   state_t               state_q;
   logic [8*NBYTES-1:0]  shadow_q;
   logic [8*NBYTES-1:0]  man_q;
   logic [IDX_W-1:0]     idx_q;
   logic [TMR_W-1:0]     timer_q;
   logic                 done_q;
   logic                 err_q;
   logic                 busy_q;

   // NOTE: reset is sampled on the clock edge only (synchronous), and every
   // state register is written with <= so all updates land together at the
   // edge regardless of statement order inside the block.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         shadow_q <= '0;
         man_q    <= '0;
         idx_q    <= '0;
         timer_q  <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         // Pulses default low and are raised only by the transition below.
         done_q <= 1'b0;
         err_q  <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               // rx_ready is deliberately ignored here.
               if (en_rxMAN) begin
                  state_q <= ST_WAIT_BYTE;
                  busy_q  <= 1'b1;
                  idx_q   <= '0;
                  timer_q <= '0;
               end
            end

            ST_WAIT_BYTE: begin
               if (rx_ready) begin
                  // A byte arriving in the same cycle as the timer limit wins.
                  for (int i = 0; i < NBYTES; i++) begin
                     if (idx_q == IDX_W'(i)) begin
                        shadow_q[8*i +: 8] <= rx_data;
                     end
                  end
                  idx_q   <= idx_q + 1'b1;
                  timer_q <= '0;
                  if (idx_q == LAST_IDX) begin
                     state_q <= ST_FINISH;
                  end
               end else if (idx_q != '0) begin
                  // Inter-byte timer only runs once the first byte is in.
                  if (timer_q == TMR_LIMIT) begin
                     state_q <= ST_ERROR;
                     err_q   <= 1'b1;
                  end else if (timer_q != TMR_MAX) begin
                     timer_q <= timer_q + 1'b1;
                  end
               end
            end

            ST_FINISH: begin
               man_q   <= shadow_q;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end

            ST_ERROR: begin
               // man keeps the last good word; only the partial word is dropped.
               shadow_q <= '0;
               busy_q   <= 1'b0;
               state_q  <= ST_IDLE;
            end

            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign man         = man_q;
   assign done_rxMAN  = done_q;
   assign timeout_err = err_q;
   assign busy        = busy_q;

endmodule
